sar_search: RTL and testbench



---
 rtl/sar_search_if.sv | 61 ++++++
 rtl/sar_search.sv | 214 +++++++++++++++++++++
 tb/tb_sar_search.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_if.sv
// ---------------------------------------------------------------------------
// sar_search_if
//   Groups the signals between the successive-approximation search engine and
//   the combinational 3-bit comparator (bit3C family) that it exercises.
//
//   Signals
//     start    search request (pulse while the engine is idle)
//     equals   comparator flag, A == guess
//     greater  comparator flag, A >  guess
//     lesser   comparator flag, A <  guess
//     guess    trial value, drives the comparator B operand
//     busy     search in progress
//     done     one-cycle end-of-search pulse
//     found    final candidate matched A on the verify step
//     err      comparator flags were not one-hot at some sample point
//     result   recovered value
//
//   Modports
//     master   the search engine (drives guess and the status outputs)
//     slave    the environment: comparator flags plus the start request
// ---------------------------------------------------------------------------
interface sar_search_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             equals;
    logic             greater;
    logic             lesser;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             found;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        input  start,
        input  equals,
        input  greater,
        input  lesser,
        output guess,
        output busy,
        output done,
        output found,
        output err,
        output result
    );

    modport slave (
        output start,
        output equals,
        output greater,
        output lesser,
        input  guess,
        input  busy,
        input  done,
        input  found,
        input  err,
        input  result
    );
endinterface

// File: rtl/sar_search.sv
// ---------------------------------------------------------------------------
// sar_search
//   Successive-approximation search engine for a combinational magnitude
//   comparator. The engine drives the comparator B operand (guess), samples
//   its equals/greater/lesser flags once per cycle and recovers the unknown
//   value on the comparator A operand, MSB first, followed by one verify
//   cycle that confirms the final candidate.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   sar_search_if.master: start, flags in; guess, busy, done, found,
//           err, result out
//
//   Parameter
//     WIDTH operand width (>= 2); also the number of probe cycles
//
//   Build option
//     SAR_SEARCH_EARLY_EXIT_EN  when defined, a consistent equals flag seen
//                               during a probe ends the search immediately
//                               with found=1. When undefined the search
//                               always takes WIDTH+2 cycles.
//
//   Timing (start sampled at edge E)
//     probes     cycles E+1 .. E+WIDTH
//     verify     cycle  E+WIDTH+1
//     done=1     cycle  E+WIDTH+2 (busy already low)
// ---------------------------------------------------------------------------
module sar_search #(
    parameter int WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    sar_search_if.master  bus
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] GUESS_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = '0;
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [WIDTH-1:0] guess_q,  guess_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             found_q,  found_d;
    logic             err_q,    err_d;
    logic [WIDTH-1:0] result_q, result_d;

    // -----------------------------------------------------------------------
    // One-hot mask of the bit currently under test. The mask of the next
    // (lower) bit is simply this mask shifted right; at idx=0 it becomes zero,
    // which is harmless because no further bit is set in that case.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] next_mask;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit_mask
            assign bit_mask[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    assign next_mask = bit_mask >> 1;

    // -----------------------------------------------------------------------
    // Comparator flag decode. A healthy comparator raises exactly one flag;
    // anything else (none, or several) is treated as a fault.
    // -----------------------------------------------------------------------
    logic flags_ok;
    logic [WIDTH-1:0] guess_kept;

    assign flags_ok = ( bus.equals & ~bus.greater & ~bus.lesser) |
                      (~bus.equals &  bus.greater & ~bus.lesser) |
                      (~bus.equals & ~bus.greater &  bus.lesser);

    // A below the trial value: the bit under test must be zero. Otherwise
    // (equal or greater) the bit stays set.
    assign guess_kept = bus.lesser ? (guess_q & ~bit_mask) : guess_q;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = err_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_PROBE;
                    guess_d  = GUESS_MSB;
                    idx_d    = IDX_TOP;
                    busy_d   = 1'b1;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                end
            end

            ST_PROBE: begin
                if (!flags_ok) begin
                    // Abort: report the bits resolved so far, with the bit
                    // under test cleared since its outcome is unknown.
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = guess_q & ~bit_mask;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
                end else if (bus.equals) begin
                    // Exact hit on a probe: the remaining probes and the
                    // verify cycle cannot change the outcome.
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    found_d  = 1'b1;
                    result_d = guess_q;
`endif
                end else if (idx_q != IDX_ZERO) begin
                    guess_d = guess_kept | next_mask;
                    idx_d   = idx_q - IDX_ONE;
                end else begin
                    // Last bit resolved; guess now holds the final candidate
                    // and is presented unchanged during the verify cycle.
                    guess_d = guess_kept;
                    state_d = ST_VERIFY;
                end
            end

            ST_VERIFY: begin
                state_d  = ST_DONE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                result_d = guess_q;
                if (!flags_ok) begin
                    err_d   = 1'b1;
                    found_d = 1'b0;
                end else begin
                    found_d = bus.equals;
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here; a new search can
                // only be launched from IDLE.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers. Reset acts immediately, so a search interrupted by reset
    // never produces a done pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            guess_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs are driven straight from registers.
    // -----------------------------------------------------------------------
    assign bus.guess  = guess_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// ---------------------------------------------------------------------------
// tb_sar_search
//   Directed bench for sar_search (WIDTH=3). A behavioural comparator drives
//   the flags from a_val and the DUT guess; force_zero pulls all flags low to
//   emulate a broken comparator. Expected values are hand-computed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sar_search;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] a_val;
    logic       force_zero;

    int n_checks = 0;
    int n_fail   = 0;

    sar_search_if #(.WIDTH(3)) bus ();

    assign bus.start   = start;
    assign bus.equals  = force_zero ? 1'b0 : (a_val == bus.guess);
    assign bus.greater = force_zero ? 1'b0 : (a_val >  bus.guess);
    assign bus.lesser  = force_zero ? 1'b0 : (a_val <  bus.guess);

    sar_search #(.WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full-length search from IDLE; g0..g2 are the probe guesses, gv the
    // verify guess. Leaves the DUT in IDLE, one cycle after done.
    task automatic run_search(input string name, input logic [2:0] a,
                              input logic [2:0] g0, input logic [2:0] g1,
                              input logic [2:0] g2, input logic [2:0] gv,
                              input logic [2:0] res, input logic fnd);
        a_val = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, ".probe0"}, bus.guess, g0);
        check({name, ".busy"},   bus.busy,  1);
        tick();
        check({name, ".probe1"}, bus.guess, g1);
        tick();
        check({name, ".probe2"}, bus.guess, g2);
        tick();
        check({name, ".verify"}, bus.guess, gv);
        check({name, ".nodone"}, bus.done,  0);
        tick();
        check({name, ".done"},   bus.done,   1);
        check({name, ".busy0"},  bus.busy,   0);
        check({name, ".result"}, bus.result, res);
        check({name, ".found"},  bus.found,  fnd);
        check({name, ".err"},    bus.err,    0);
        tick();
        check({name, ".pulse"},  bus.done,   0);
        check({name, ".hold"},   bus.result, res);
        check({name, ".ghold"},  bus.guess,  gv);
        $display("txn %s A=%b result=%b found=%b", name, a, bus.result, bus.found);
    endtask

    initial begin
        int done_seen;
        rst        = 1'b1;
        start      = 1'b0;
        a_val      = 3'b000;
        force_zero = 1'b0;

        tick();
        check("rst.guess",  bus.guess,  0);
        check("rst.busy",   bus.busy,   0);
        check("rst.done",   bus.done,   0);
        check("rst.found",  bus.found,  0);
        check("rst.err",    bus.err,    0);
        check("rst.result", bus.result, 0);
        rst = 1'b0;
        tick();
        $display("txn reset released");

        run_search("a010", 3'b010, 3'b100, 3'b010, 3'b011, 3'b010, 3'b010, 1'b1);
        run_search("a111", 3'b111, 3'b100, 3'b110, 3'b111, 3'b111, 3'b111, 1'b1);
        run_search("a000", 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 1'b1);

`ifdef SAR_SEARCH_EARLY_EXIT_EN
        a_val = 3'b100;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("early.probe0", bus.guess, 3'b100);
        tick();
        check("early.done",   bus.done,   1);
        check("early.result", bus.result, 3'b100);
        check("early.found",  bus.found,  1);
        tick();
        $display("txn early-exit A=100 result=%b", bus.result);
`else
        run_search("a100", 3'b100, 3'b100, 3'b110, 3'b101, 3'b100, 3'b100, 1'b1);
`endif

        // A changes after the first probe: 010 -> 110
        a_val = 3'b010;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("chg.probe0", bus.guess, 3'b100);
        tick();
        a_val = 3'b110;
        check("chg.probe1", bus.guess, 3'b010);
        tick();
        check("chg.probe2", bus.guess, 3'b011);
        tick();
        check("chg.verify", bus.guess, 3'b011);
        tick();
        check("chg.done",   bus.done,   1);
        check("chg.result", bus.result, 3'b011);
        check("chg.found",  bus.found,  0);
        check("chg.err",    bus.err,    0);
        tick();
        $display("txn A-change result=%b found=%b", bus.result, bus.found);

        // Dead flags during the second probe (guess 110 for A=110)
        a_val = 3'b110;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("flt.probe1", bus.guess, 3'b110);
        force_zero = 1'b1;
        tick();
        force_zero = 1'b0;
        check("flt.done",   bus.done,   1);
        check("flt.err",    bus.err,    1);
        check("flt.found",  bus.found,  0);
        check("flt.result", bus.result, 3'b100);
        check("flt.busy",   bus.busy,   0);
        tick();
        check("flt.errhold", bus.err, 1);
        $display("txn flag-fault err=%b result=%b", bus.err, bus.result);

        // start while busy and in DONE: ignored
        a_val = 3'b101;
        start = 1'b1;
        tick();
        check("sb.probe0", bus.guess, 3'b100);
        tick();
        check("sb.probe1", bus.guess, 3'b110);
        tick();
        check("sb.probe2", bus.guess, 3'b101);
        tick();
        check("sb.verify", bus.guess, 3'b101);
        tick();
        check("sb.done",   bus.done,   1);
        check("sb.result", bus.result, 3'b101);
        check("sb.err",    bus.err,    0);
        tick();
        start = 1'b0;
        check("sb.idle_busy", bus.busy, 0);
        check("sb.idle_done", bus.done, 0);
        tick();
        check("sb.still_idle", bus.busy, 0);
        $display("txn start-while-busy result=%b", bus.result);

        // Asynchronous reset mid-probe
        a_val = 3'b011;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("mrst.guess",  bus.guess,  0);
        check("mrst.busy",   bus.busy,   0);
        check("mrst.done",   bus.done,   0);
        check("mrst.result", bus.result, 0);
        check("mrst.found",  bus.found,  0);
        check("mrst.err",    bus.err,    0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.done === 1'b1) done_seen++;
        end
        check("mrst.nodone", done_seen, 0);
        check("mrst.idle",   bus.busy,  0);
        $display("txn reset mid-search done_pulses=%0d", done_seen);

        run_search("a011", 3'b011, 3'b100, 3'b010, 3'b011, 3'b011, 3'b011, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
